gmii_phy_rx_gen: RTL and testbench
==================================

GMII_PHY_RX_GEN -- requirements
Module: gmii_phy_rx_gen

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 7: number of 0x55 bytes sent before SFD (legal 1..15).
REQ-002 SHALL have parameter IFG_MIN, default 12: minimum idle cycles between frames (legal 1..255).
REQ-003 SHALL have these ports, with one clock; reset is asynchronous and active-high:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous active-high reset.
- s_axis_tdata  input  8  payload byte.
- s_axis_tvalid  input  1  payload valid.
- s_axis_tready  output  1  payload accepted.
- s_axis_tlast  input  1  last payload byte.
- s_axis_tuser  input  1  inject rx_er on this byte.
- gmii_rxd  output  8  GMII receive data toward the MAC.
- gmii_rx_dv  output  1  receive data valid.
- gmii_rx_er  output  1  receive error.
- busy  output  1  frame or IFG in progress.
- frame_done  output  1  one-cycle pulse at the end of a completed frame.
- underflow  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-004 SHALL implement the states IDLE, PREAMBLE, SFD, DATA, FCS and IFG; all GMII outputs SHALL be registered.
REQ-005 IDLE: gmii_rx_dv=0, gmii_rx_er=0, gmii_rxd=0x00, s_axis_tready=0; when tvalid=1, go to PREAMBLE; the first 0x55 appears with dv=1 in the next cycle.
REQ-006 PREAMBLE SHALL drive 0x55 with dv=1 for exactly PREAMBLE_LEN cycles, counted by a 4-bit counter; then SFD SHALL drive 0xD5 for one cycle.
REQ-007 DATA: s_axis_tready=1 combinationally; each accepted byte SHALL appear on gmii_rxd the next cycle with dv=1, er=tuser; one byte per cycle, zero bubbles.
REQ-008 Accepting a byte with tlast=1 SHALL transition to FCS (REQ-018) or to IFG, and SHALL pulse frame_done in the cycle the last frame byte is on gmii_rxd.
REQ-009 tvalid=0 while in DATA SHALL be treated as an underflow: the next cycle drives dv=1, er=1, rxd=0x00 and pulses underflow; no FCS is sent; the state goes to IFG; any later bytes of that frame are accepted in IDLE as a new frame.
REQ-010 IFG SHALL hold dv=0, er=0, rxd=0x00 for exactly IFG_MIN cycles, counted by an 8-bit counter; then go to IDLE.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 A tvalid present during IFG SHALL be held off with tready=0 and SHALL start the preamble in the cycle after IFG ends.
REQ-013 A single-byte frame (tvalid and tlast on the first beat) SHALL be legal; no minimum frame length is enforced and no padding is added.

Reset
REQ-014 Reset SHALL put the block in IDLE: gmii_rxd=0x00, gmii_rx_dv=0, gmii_rx_er=0, busy=0, frame_done=0, underflow=0, tready=0, counters 0, CRC=0xFFFFFFFF.
REQ-015 Reset asserted mid-frame SHALL drop dv within the same cycle, asynchronously; the partial frame is discarded.
REQ-016 After reset deassertion there SHALL be no IFG; a new frame may start on the first clock edge.

Configuration
REQ-017 Macro GMII_PHY_RX_GEN_FCS_EN SHALL select whether the FCS is generated.
REQ-018 With GMII_PHY_RX_GEN_FCS_EN defined:
- a CRC-32 is computed over the payload bytes only: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, result inverted;
- after tlast, FCS drives 4 bytes with dv=1, er=0, least-significant byte first;
- frame_done pulses with the 4th FCS byte;
- the CRC is reinitialised in SFD.
REQ-019 With GMII_PHY_RX_GEN_FCS_EN undefined: the FCS state and CRC logic are absent; the payload is sent verbatim, so any FCS is supplied by the caller.

Structure
REQ-020 Shared package eth_gmii_pkg SHALL hold:
- ETH_PREAMBLE=0x55, ETH_SFD=0xD5;
- ETH_CRC_POLY=0xEDB88320, ETH_CRC_INIT=0xFFFFFFFF, ETH_CRC_RESIDUE=0xDEBB20E3;
- the state encoding.
REQ-021 The byte-wide CRC update SHALL be a combinational sub-module eth_crc32_d8 (inputs: crc_in[31:0], data[7:0]; output: crc_out[31:0]), reusable by the MAC-side checker.

Verification
REQ-022 Bytes "123456789" (0x31..0x39) with FCS_EN defined -> 7x0x55, 0xD5, 9 payload bytes, then 0x26,0x39,0xF4,0xCB; dv high for 21 cycles; one frame_done pulse.
REQ-023 60-byte frame 0x00..0x3B, FCS_EN defined -> dv high for 72 consecutive cycles; the MAC-side CRC over payload+FCS equals 0xDEBB20E3.
REQ-024 Two back-to-back 1-byte frames, IFG_MIN=12 -> exactly 12 dv=0 cycles between the 4th FCS byte of frame 1 and the first 0x55 of frame 2.
REQ-025 tvalid dropped after payload byte 5 of 10 -> byte 6 slot shows dv=1, er=1, rxd=0x00; one underflow pulse; no FCS; then 12 idle cycles.
REQ-026 tuser=1 on payload byte 3 -> er=1 only on that output cycle; with FCS_EN the FCS is still computed over all bytes.
REQ-027 rst asserted during the preamble -> dv=0 before the next edge; after release, tvalid=1 -> 0x55 on the following cycle; FCS_EN undefined -> dv high exactly 8 + N cycles for an N-byte payload.

Source files
------------

// File: rtl/eth_gmii_pkg.sv
// Shared Ethernet/GMII constants and the receive-generator state encoding.
// Used by the PHY-side frame generator and the MAC-side CRC checker.
package eth_gmii_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_FCS,
      ST_IFG
   } rx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide update of the reflected Ethernet CRC-32 (no init, no final inversion).
// Shared by the frame generator and the MAC-side FCS checker.
module eth_crc32_d8
   import eth_gmii_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      // Reflected CRC: the data byte enters at the LSB end and shifts right one bit per step.
      c = crc_in ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/gmii_phy_rx_gen.sv
// Turns an AXI-Stream payload into a GMII receive frame (preamble, SFD, data, optional FCS, IFG).
// Define GMII_PHY_RX_GEN_FCS_EN to append a generated CRC-32 FCS; otherwise the payload is sent verbatim.
module gmii_phy_rx_gen
   import eth_gmii_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_MIN      = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] gmii_rxd,
   output logic       gmii_rx_dv,
   output logic       gmii_rx_er,
   output logic       busy,
   output logic       frame_done,
   output logic       underflow
);

   rx_state_e  state_q, state_d;
   logic [3:0] pre_cnt_q, pre_cnt_d;
   logic [7:0] ifg_cnt_q, ifg_cnt_d;
   logic [7:0] rxd_q, rxd_d;
   logic       dv_q, dv_d;
   logic       er_q, er_d;
   logic       done_q, done_d;
   logic       uf_q, uf_d;

`ifdef GMII_PHY_RX_GEN_FCS_EN
   logic [31:0] crc_q, crc_d, crc_upd, fcs;
   logic [1:0]  fcs_idx_q, fcs_idx_d;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (s_axis_tdata),
      .crc_out (crc_upd)
   );

   assign fcs = ~crc_q;
`endif

   // The state register describes the decision being made this cycle; the wire shows it one cycle later.
   assign s_axis_tready = (state_q == ST_SFD) || (state_q == ST_DATA);
   assign busy          = (state_q != ST_IDLE);
   assign gmii_rxd      = rxd_q;
   assign gmii_rx_dv    = dv_q;
   assign gmii_rx_er    = er_q;
   assign frame_done    = done_q;
   assign underflow     = uf_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      ifg_cnt_d = ifg_cnt_q;
      rxd_d     = 8'h00;
      dv_d      = 1'b0;
      er_d      = 1'b0;
      done_d    = 1'b0;
      uf_d      = 1'b0;
`ifdef GMII_PHY_RX_GEN_FCS_EN
      crc_d     = crc_q;
      fcs_idx_d = fcs_idx_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               state_d   = ST_PREAMBLE;
               pre_cnt_d = 4'd1;
               rxd_d     = ETH_PREAMBLE;
               dv_d      = 1'b1;
            end
         end

         ST_PREAMBLE: begin
            dv_d = 1'b1;
            if (pre_cnt_q == 4'(PREAMBLE_LEN)) begin
               state_d   = ST_SFD;
               pre_cnt_d = 4'd0;
               rxd_d     = ETH_SFD;
`ifdef GMII_PHY_RX_GEN_FCS_EN
               crc_d     = ETH_CRC_INIT;
`endif
            end else begin
               pre_cnt_d = pre_cnt_q + 4'd1;
               rxd_d     = ETH_PREAMBLE;
            end
         end

         // SFD is on the wire while the first payload byte is accepted, so data follows with no bubble.
         ST_SFD, ST_DATA: begin
            dv_d = 1'b1;
            if (!s_axis_tvalid) begin
               er_d      = 1'b1;
               uf_d      = 1'b1;
               state_d   = ST_IFG;
               ifg_cnt_d = 8'd0;
            end else begin
               rxd_d   = s_axis_tdata;
               er_d    = s_axis_tuser;
               state_d = ST_DATA;
`ifdef GMII_PHY_RX_GEN_FCS_EN
               crc_d   = crc_upd;
               if (s_axis_tlast) begin
                  state_d   = ST_FCS;
                  fcs_idx_d = 2'd0;
               end
`else
               if (s_axis_tlast) begin
                  state_d   = ST_IFG;
                  ifg_cnt_d = 8'd0;
                  done_d    = 1'b1;
               end
`endif
            end
         end

`ifdef GMII_PHY_RX_GEN_FCS_EN
         ST_FCS: begin
            dv_d      = 1'b1;
            rxd_d     = fcs[{fcs_idx_q, 3'b000} +: 8];
            fcs_idx_d = fcs_idx_q + 2'd1;
            if (fcs_idx_q == 2'd3) begin
               done_d    = 1'b1;
               state_d   = ST_IFG;
               ifg_cnt_d = 8'd0;
            end
         end
`endif

         // IFG is entered while the final symbol is on the wire, so IFG_MIN cycles here give IFG_MIN idle wire cycles.
         ST_IFG: begin
            if (ifg_cnt_q == 8'(IFG_MIN - 1)) begin
               state_d   = ST_IDLE;
               ifg_cnt_d = 8'd0;
            end else begin
               ifg_cnt_d = ifg_cnt_q + 8'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= 4'd0;
         ifg_cnt_q <= 8'd0;
         rxd_q     <= 8'h00;
         dv_q      <= 1'b0;
         er_q      <= 1'b0;
         done_q    <= 1'b0;
         uf_q      <= 1'b0;
`ifdef GMII_PHY_RX_GEN_FCS_EN
         crc_q     <= ETH_CRC_INIT;
         fcs_idx_q <= 2'd0;
`endif
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         ifg_cnt_q <= ifg_cnt_d;
         rxd_q     <= rxd_d;
         dv_q      <= dv_d;
         er_q      <= er_d;
         done_q    <= done_d;
         uf_q      <= uf_d;
`ifdef GMII_PHY_RX_GEN_FCS_EN
         crc_q     <= crc_d;
         fcs_idx_q <= fcs_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_gmii_phy_rx_gen.sv
// Randomized self-checking bench for gmii_phy_rx_gen: a frame-level model predicts every wire symbol
// and the start cycle of every frame; honours GMII_PHY_RX_GEN_FCS_EN like the design.
module tb_gmii_phy_rx_gen;

   localparam int PRE   = 7;
   localparam int IFG   = 12;
   localparam int NRAND = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_axis_tdata  = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tlast  = 1'b0;
   logic       s_axis_tuser  = 1'b0;
   logic       s_axis_tready;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv, gmii_rx_er, busy, frame_done, underflow;

   gmii_phy_rx_gen #(.PREAMBLE_LEN(PRE), .IFG_MIN(IFG)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .gmii_rxd      (gmii_rxd),
      .gmii_rx_dv    (gmii_rx_dv),
      .gmii_rx_er    (gmii_rx_er),
      .busy          (busy),
      .frame_done    (frame_done),
      .underflow     (underflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Bit-serial reflected CRC-32, one data bit at a time.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   // Expected wire symbols: {last, frame_done, underflow, er, rxd}
   logic [11:0] exp_q[$];
   int          tv_q[$];
   logic [7:0]  pay[64];
   logic        usr[64];

   task automatic push_frame(input int a, input int b, input bit uf);
      bit lastb;
`ifdef GMII_PHY_RX_GEN_FCS_EN
      logic [31:0] c;
      logic [31:0] f;
      c = 32'hFFFFFFFF;
`endif
      for (int i = 0; i < PRE; i++) exp_q.push_back({4'b0000, 8'h55});
      exp_q.push_back({4'b0000, 8'hD5});
      for (int j = a; j < b; j++) begin
`ifdef GMII_PHY_RX_GEN_FCS_EN
         lastb = 1'b0;
         c = crc_step(c, pay[j]);
`else
         lastb = !uf && (j == b - 1);
`endif
         exp_q.push_back({lastb, lastb, 1'b0, usr[j], pay[j]});
      end
      if (uf) begin
         exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 8'h00});
      end else begin
`ifdef GMII_PHY_RX_GEN_FCS_EN
         f = ~c;
         for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, k == 3, 2'b00, f[8*k +: 8]});
`endif
      end
   endtask

   // Monitor: samples on the falling edge, compares every cycle against the model.
   bit          mon_en   = 1'b0;
   bit          in_burst = 1'b0;
   bit          have_prev = 1'b0;
   int          last_cyc = 0;
   int          tv       = 0;
   int          exp_start = 0;
   logic [11:0] mon_e;
`ifdef GMII_PHY_RX_GEN_FCS_EN
   int          sym_idx = 0;
   logic [31:0] mon_crc = 32'hFFFFFFFF;
`endif

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (gmii_rx_dv) begin
               if (!in_burst) begin
                  in_burst = 1'b1;
`ifdef GMII_PHY_RX_GEN_FCS_EN
                  sym_idx = 0;
                  mon_crc = 32'hFFFFFFFF;
`endif
                  if (tv_q.size() == 0) begin
                     check("start_unplanned", tv_q.size(), 1);
                  end else begin
                     tv = tv_q.pop_front();
                     exp_start = tv + 1;
                     if (have_prev && (last_cyc + IFG + 1 > exp_start)) exp_start = last_cyc + IFG + 1;
                     check("start_cycle", cyc, exp_start);
                  end
               end
               check("busy_in_frame", busy, 1'b1);
               if (exp_q.size() == 0) begin
                  check("extra_symbol", exp_q.size(), 1);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("symbol", {frame_done, underflow, gmii_rx_er, gmii_rxd}, mon_e[10:0]);
`ifdef GMII_PHY_RX_GEN_FCS_EN
                  if (sym_idx > PRE) mon_crc = crc_step(mon_crc, gmii_rxd);
                  sym_idx++;
`endif
                  if (mon_e[11]) begin
                     in_burst  = 1'b0;
                     have_prev = 1'b1;
                     last_cyc  = cyc;
`ifdef GMII_PHY_RX_GEN_FCS_EN
                     if (!mon_e[9]) check("fcs_residue", mon_crc, 32'hDEBB20E3);
`endif
                  end
               end
            end else begin
               if (in_burst) begin
                  check("burst_short", in_burst, 1'b0);
                  in_burst = 1'b0;
               end
               check("idle_outputs", {s_axis_tready, frame_done, underflow, gmii_rx_er, gmii_rxd}, 12'h000);
            end
         end
      end
   end

   // Driver: called and returns at posedge+1; records the cycle tvalid first rises for each wire frame.
   task automatic run_frame(input int n, input int uf_at, input int wait0);
      int idx;
      bit first;
      bit hs;
      int guard;
      idx = 0;
      first = 1'b1;
      guard = 0;
      repeat (wait0) begin
         @(posedge clk);
         #1;
      end
      push_frame(0, (uf_at != 0) ? uf_at : n, uf_at != 0);
      while (idx < n) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = pay[idx];
         s_axis_tlast  = (idx == n - 1);
         s_axis_tuser  = usr[idx];
         if (first) begin
            tv_q.push_back(cyc);
            first = 1'b0;
         end
         @(negedge clk);
         hs = s_axis_tready;
         @(posedge clk);
         #1;
         if (hs) begin
            idx++;
            guard = 0;
            if (uf_at != 0 && idx == uf_at) begin
               s_axis_tvalid = 1'b0;
               s_axis_tdata  = 8'($urandom);
               s_axis_tlast  = 1'b0;
               s_axis_tuser  = 1'b0;
               @(posedge clk);
               #1;
               first = 1'b1;
               push_frame(uf_at, n, 1'b0);
            end
         end else begin
            guard++;
            if (guard > 200) begin
               check("handshake_timeout", guard, 0);
               s_axis_tvalid = 1'b0;
               return;
            end
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 4000 && (exp_q.size() != 0 || in_burst); i++) @(posedge clk);
      repeat (IFG + 2) @(posedge clk);
      #1;
      check("drain_symbols", exp_q.size(), 0);
      check("drain_starts", tv_q.size(), 0);
   endtask

   task automatic reset_mid_preamble();
      bit seen;
      seen = 1'b0;
      mon_en = 1'b0;
      s_axis_tdata  = 8'h11;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = gmii_rx_dv;
      end
      check("pre_rst_dv_seen", seen, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_preamble", {gmii_rx_dv, gmii_rxd}, {1'b1, 8'h55});
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_dv", gmii_rx_dv, 1'b0);
      check("rst_async_busy", busy, 1'b0);
      check("rst_async_rxd", gmii_rxd, 8'h00);
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      tv_q.delete();
      in_burst  = 1'b0;
      have_prev = 1'b0;
      mon_en    = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, uf, w;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rxd", gmii_rxd, 8'h00);
      check("reset_dv", gmii_rx_dv, 1'b0);
      check("reset_er", gmii_rx_er, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_frame_done", frame_done, 1'b0);
      check("reset_underflow", underflow, 1'b0);
      check("reset_tready", s_axis_tready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // "123456789" straight out of reset
      for (int i = 0; i < 9; i++) begin
         pay[i] = 8'h31 + 8'(i);
         usr[i] = 1'b0;
      end
      run_frame(9, 0, 0);

      // 60-byte ramp
      for (int i = 0; i < 60; i++) begin
         pay[i] = 8'(i);
         usr[i] = 1'b0;
      end
      run_frame(60, 0, 3);

      // two back-to-back single-byte frames
      pay[0] = 8'hA5;
      usr[0] = 1'b0;
      run_frame(1, 0, 0);
      pay[0] = 8'h3C;
      run_frame(1, 0, 0);

      // tvalid dropped after byte 5 of 10
      for (int i = 0; i < 10; i++) begin
         pay[i] = 8'($urandom);
         usr[i] = 1'b0;
      end
      run_frame(10, 5, 0);

      // error injected on payload byte 3
      for (int i = 0; i < 8; i++) begin
         pay[i] = 8'($urandom);
         usr[i] = (i == 2);
      end
      run_frame(8, 0, 2);
      wait_drain();

      reset_mid_preamble();
      for (int i = 0; i < 6; i++) begin
         pay[i] = 8'($urandom);
         usr[i] = 1'b0;
      end
      run_frame(6, 0, 0);

      for (int f = 0; f < NRAND; f++) begin
         n  = $urandom_range(1, 24);
         uf = 0;
         w  = 0;
         for (int j = 0; j < n; j++) begin
            pay[j] = 8'($urandom);
            usr[j] = ($urandom_range(0, 9) == 0);
         end
         if (n > 1 && $urandom_range(0, 3) == 0) uf = $urandom_range(1, n - 1);
         if ($urandom_range(0, 2) == 0) w = $urandom_range(1, 20);
         run_frame(n, uf, w);
      end
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
